// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : decode_pkg
//  Purpose  : Shared types and constants for the decode-stage scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

  // Width of the opaque control bundle carried alongside each instruction.
  localparam int CTRL_W     = 8;
  // Register index width for the default 16-entry register file.
  localparam int REG_AW     = 4;
  // Operand width of the default configuration.
  localparam int DATA_W_DEF = 16;

  typedef logic [REG_AW-1:0] regaddr_t;

  // Hazard policy: stall on any pending source, or only on load-use.
  typedef enum logic {
    FWD_OFF      = 1'b0,
    FWD_LOAD_USE = 1'b1
  } fwd_mode_e;

  // ID/EX slot contents in the default configuration.
  typedef struct packed {
    regaddr_t              rd;
    logic                  we;
    logic [DATA_W_DEF-1:0] rs_data;
    logic [DATA_W_DEF-1:0] rt_data;
    logic [CTRL_W-1:0]     ctrl;
  } idex_payload_t;

endpackage
`default_nettype wire

// File: rtl/sb_entry.sv
`default_nettype none
// ============================================================================
//  Module   : sb_entry
//  Purpose  : One scoreboard entry: cycles-to-writeback counter plus a flag
//             marking the pending write as a memory load.
//  Revision : 1.0 - initial release
// ============================================================================
module sb_entry #(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = $clog2(WB_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             set_ld,
  input  logic             clr,
  input  logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic             ld
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WB_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ld;

  // A new write reloads the entry (newest writer wins), a squash empties it,
  // otherwise it counts down on every cycle the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_ld  <= 1'b0;
    end else if (set) begin
      r_cnt <= CNT_LOAD;
      r_ld  <= set_ld;
    end else if (clr) begin
      r_cnt <= '0;
      r_ld  <= 1'b0;
    end else if (tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_ONE;
      if (r_cnt == CNT_ONE) begin
        r_ld <= 1'b0;
      end
    end
  end

  assign cnt = r_cnt;
  assign ld  = r_ld;

endmodule
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : decode_scoreboard
//  Purpose  : Decode-stage RAW hazard scoreboard with a single ID/EX slot,
//             optional load-use-only stalling, flush and stall accounting.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16,
  parameter int WB_LAT   = 3,
  parameter int FWD_EN   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [$clog2(NUM_REGS)-1:0] in_rs,
  input  logic [$clog2(NUM_REGS)-1:0] in_rt,
  input  logic [$clog2(NUM_REGS)-1:0] in_rd,
  input  logic                        in_use_rs,
  input  logic                        in_use_rt,
  input  logic                        in_we,
  input  logic                        in_is_load,
  input  logic [DATA_W-1:0]           in_rs_data,
  input  logic [DATA_W-1:0]           in_rt_data,
  input  logic [CTRL_W-1:0]           in_ctrl,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NUM_REGS)-1:0] out_rd,
  output logic                        out_we,
  output logic [DATA_W-1:0]           out_rs_data,
  output logic [DATA_W-1:0]           out_rt_data,
  output logic [CTRL_W-1:0]           out_ctrl,
  input  logic                        flush,
  output logic                        stall,
  output logic [15:0]                 stall_cnt
);

  localparam int               RA_W     = $clog2(NUM_REGS);
  localparam int               CNT_W    = $clog2(WB_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WB_LAT);
  localparam fwd_mode_e        FWD_MODE = (FWD_EN != 0) ? FWD_LOAD_USE : FWD_OFF;

  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
  logic [NUM_REGS-1:0]            w_ld;
  logic w_adv, w_issue, w_stall, w_kill;
  logic w_rs_hz, w_rt_hz;

  logic              r_out_valid;
  logic              r_out_we;
  logic [RA_W-1:0]   r_out_rd;
  logic [DATA_W-1:0] r_out_rs_data;
  logic [DATA_W-1:0] r_out_rt_data;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [15:0]       r_stall_cnt;

  // Register 0 is hard-wired and never pending.
  assign w_cnt[0] = '0;
  assign w_ld[0]  = 1'b0;

  // Source hazard check; with forwarding only a load still in its first
  // cycle after capture is unavailable to the next instruction.
  always_comb begin
    w_rs_hz = 1'b0;
    w_rt_hz = 1'b0;
    if (FWD_MODE == FWD_LOAD_USE) begin
      w_rs_hz = in_use_rs && w_ld[in_rs] && (w_cnt[in_rs] == CNT_FULL);
      w_rt_hz = in_use_rt && w_ld[in_rt] && (w_cnt[in_rt] == CNT_FULL);
    end else begin
      w_rs_hz = in_use_rs && (w_cnt[in_rs] != '0);
      w_rt_hz = in_use_rt && (w_cnt[in_rt] != '0);
    end
  end

  // Reset masks stale counters so no stall is reported while it is applied.
  assign w_stall  = in_valid & (w_rs_hz | w_rt_hz) & ~flush & ~rst;
  assign w_adv    = out_ready | ~r_out_valid;
  assign in_ready = w_adv & ~w_stall & ~flush;
  assign w_issue  = in_valid & in_ready;
  // A squashed slot that was going to write must release its destination.
  assign w_kill   = flush & r_out_valid & r_out_we;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    logic w_set, w_clr;
    assign w_set = w_issue & in_we & (in_rd == RA_W'(r));
    assign w_clr = w_kill & (r_out_rd == RA_W'(r));

    sb_entry #(
      .WB_LAT (WB_LAT),
      .CNT_W  (CNT_W)
    ) u_entry (
      .clk    (clk),
      .rst    (rst),
      .set    (w_set),
      .set_ld (in_is_load),
      .clr    (w_clr),
      .tick   (out_ready),
      .cnt    (w_cnt[r]),
      .ld     (w_ld[r])
    );
  end

  // ID/EX slot: capture on issue, bubble when advancing without issue, hold
  // under backpressure; also accumulates hazard-stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_we      <= 1'b0;
      r_out_rd      <= '0;
      r_out_rs_data <= '0;
      r_out_rt_data <= '0;
      r_out_ctrl    <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
        r_out_we    <= 1'b0;
      end else if (w_adv) begin
        r_out_valid <= w_issue;
        r_out_we    <= w_issue & in_we;
        if (w_issue) begin
          r_out_rd      <= in_rd;
          r_out_rs_data <= in_rs_data;
          r_out_rt_data <= in_rt_data;
          r_out_ctrl    <= in_ctrl;
        end
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_we      = r_out_we;
  assign out_rd      = r_out_rd;
  assign out_rs_data = r_out_rs_data;
  assign out_rt_data = r_out_rt_data;
  assign out_ctrl    = r_out_ctrl;
  assign stall       = w_stall;
  assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_scoreboard
//  Purpose  : Directed self-checking bench for decode_scoreboard; instance 0
//             stalls on any pending source, instance 1 only on load-use.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_scoreboard;
  import decode_pkg::*;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, out_ready;
  logic v0, v1;
  regaddr_t rs, rt, rd;
  logic use_rs, use_rt, we, is_load;
  logic [DW-1:0] rs_data, rt_data;
  logic [CTRL_W-1:0] ctrl;

  logic rdy0, ov0, owe0, st0;
  regaddr_t ord0;
  logic [DW-1:0] ors0, ort0;
  logic [CTRL_W-1:0] octl0;
  logic [15:0] sc0;

  logic rdy1, ov1, owe1, st1;
  regaddr_t ord1;
  logic [DW-1:0] ors1, ort1;
  logic [CTRL_W-1:0] octl1;
  logic [15:0] sc1;

  int checks = 0;
  int errors = 0;
  int n;

  decode_scoreboard #(.NUM_REGS(16), .DATA_W(DW), .WB_LAT(3), .FWD_EN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0),
    .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_use_rs(use_rs), .in_use_rt(use_rt),
    .in_we(we), .in_is_load(is_load), .in_rs_data(rs_data), .in_rt_data(rt_data),
    .in_ctrl(ctrl), .out_valid(ov0), .out_ready(out_ready), .out_rd(ord0),
    .out_we(owe0), .out_rs_data(ors0), .out_rt_data(ort0), .out_ctrl(octl0),
    .flush(flush), .stall(st0), .stall_cnt(sc0)
  );

  decode_scoreboard #(.NUM_REGS(16), .DATA_W(DW), .WB_LAT(3), .FWD_EN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
    .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_use_rs(use_rs), .in_use_rt(use_rt),
    .in_we(we), .in_is_load(is_load), .in_rs_data(rs_data), .in_rt_data(rt_data),
    .in_ctrl(ctrl), .out_valid(ov1), .out_ready(out_ready), .out_rd(ord1),
    .out_we(owe1), .out_rs_data(ors1), .out_rt_data(ort1), .out_ctrl(octl1),
    .flush(flush), .stall(st1), .stall_cnt(sc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; payload data is derived from rd.
  task automatic drv(input int s0, input int s1, input int a_rs, input int a_rt,
                     input int a_rd, input int a_urs, input int a_urt,
                     input int a_we, input int a_ld);
    v0      = (s0 != 0);
    v1      = (s1 != 0);
    rs      = regaddr_t'(a_rs);
    rt      = regaddr_t'(a_rt);
    rd      = regaddr_t'(a_rd);
    use_rs  = (a_urs != 0);
    use_rt  = (a_urt != 0);
    we      = (a_we != 0);
    is_load = (a_ld != 0);
    rs_data = 16'h1000 + 16'(a_rd);
    rt_data = 16'h2000 + 16'(a_rd);
    ctrl    = 8'hC0 + 8'(a_rd);
    #1;
  endtask

  task automatic idle();
    v0 = 1'b0;
    v1 = 1'b0;
    #1;
  endtask

  // Hold the current instruction on instance 0 until accepted, counting
  // stall cycles; bounded so a stuck DUT still reaches the summary.
  task automatic count_stalls(output int cnt);
    cnt = 0;
    for (int i = 0; i < 10 && rdy0 !== 1'b1; i++) begin
      if (st0 === 1'b1) cnt++;
      tick();
    end
    chk("stall_wait_rdy", 32'(rdy0), 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    rs = '0; rt = '0; rd = '0;
    use_rs = 1'b0; use_rt = 1'b0; we = 1'b0; is_load = 1'b0;
    rs_data = '0; rt_data = '0; ctrl = '0;
    tick();
    tick();

    // Reset state
    chk("rst_ov", 32'(ov0), 0);
    chk("rst_owe", 32'(owe0), 0);
    chk("rst_ord", 32'(ord0), 0);
    chk("rst_ors", 32'(ors0), 0);
    chk("rst_octl", 32'(octl0), 0);
    chk("rst_sc", 32'(sc0), 0);
    chk("rst_ov1", 32'(ov1), 0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", 32'(rdy0), 1);

    // Back-to-back RAW: ADD r2 <- r1,r1 then SUB r6 <- r2,r3
    drv(1, 0, 1, 1, 2, 1, 1, 1, 0);
    chk("add_stall", 32'(st0), 0);
    chk("add_rdy", 32'(rdy0), 1);
    tick();
    chk("add_ov", 32'(ov0), 1);
    chk("add_ord", 32'(ord0), 2);
    chk("add_owe", 32'(owe0), 1);
    chk("add_ors", 32'(ors0), 32'h1002);
    chk("add_ort", 32'(ort0), 32'h2002);
    chk("add_octl", 32'(octl0), 32'hC2);
    drv(1, 0, 2, 3, 6, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("raw_stall", 32'(st0), 1);
      chk("raw_rdy", 32'(rdy0), 0);
      tick();
      chk("raw_bubble_ov", 32'(ov0), 0);
      chk("raw_bubble_owe", 32'(owe0), 0);
    end
    chk("raw_release_stall", 32'(st0), 0);
    chk("raw_release_rdy", 32'(rdy0), 1);
    tick();
    chk("sub_ov", 32'(ov0), 1);
    chk("sub_ord", 32'(ord0), 6);
    chk("sub_ors", 32'(ors0), 32'h1006);
    chk("raw_sc", 32'(sc0), 3);
    idle();
    tick(); tick(); tick();

    // r0 is never tracked: write r0, then read r0 on both sources
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drv(1, 0, 0, 0, 1, 1, 1, 0, 0);
    chk("r0_stall", 32'(st0), 0);
    chk("r0_rdy", 32'(rdy0), 1);
    tick();
    chk("r0_ov", 32'(ov0), 1);
    chk("r0_owe", 32'(owe0), 0);
    chk("r0_ord", 32'(ord0), 1);

    // WAW: rewrite r3 when its counter is down to 1, reload to 3
    drv(1, 0, 0, 0, 3, 0, 0, 1, 0);
    tick();
    idle();
    tick(); tick();
    drv(1, 0, 0, 0, 3, 0, 0, 1, 0);
    chk("waw_rdy", 32'(rdy0), 1);
    tick();
    drv(1, 0, 3, 0, 9, 1, 0, 0, 0);
    count_stalls(n);
    chk("waw_stalls", 32'(n), 3);
    idle();
    chk("waw_sc", 32'(sc0), 6);

    // Backpressure: cnt[r2]=2 with slot holding r8 writer, freeze 4 cycles
    drv(1, 0, 0, 0, 2, 0, 0, 1, 0);
    tick();
    drv(1, 0, 0, 0, 8, 0, 0, 1, 0);
    tick();
    idle();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_ov", 32'(ov0), 1);
      chk("bp_ord", 32'(ord0), 8);
      chk("bp_ors", 32'(ors0), 32'h1008);
      chk("bp_rdy", 32'(rdy0), 0);
    end
    out_ready = 1'b1;
    drv(1, 0, 2, 0, 10, 1, 0, 0, 0);
    count_stalls(n);
    chk("bp_stalls", 32'(n), 2);
    idle();
    chk("bp_sc", 32'(sc0), 8);
    tick(); tick(); tick();

    // Flush while slot writes r7 and decode reads r7
    drv(1, 0, 0, 0, 7, 0, 0, 1, 0);
    tick();
    drv(1, 0, 7, 0, 11, 1, 0, 1, 0);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(st0), 0);
    chk("flush_rdy", 32'(rdy0), 0);
    tick();
    chk("flush_ov", 32'(ov0), 0);
    chk("flush_owe", 32'(owe0), 0);
    flush = 1'b0;
    #1;
    chk("flush_next_stall", 32'(st0), 0);
    chk("flush_next_rdy", 32'(rdy0), 1);
    tick();
    chk("flush_next_ov", 32'(ov0), 1);
    chk("flush_next_ord", 32'(ord0), 11);
    chk("flush_sc", 32'(sc0), 8);
    idle();
    tick(); tick(); tick();

    // Reset mid-stall with cnt[r4]=2
    drv(1, 0, 0, 0, 4, 0, 0, 1, 0);
    tick();
    idle();
    tick();
    drv(1, 0, 4, 0, 12, 1, 0, 0, 0);
    chk("prerst_stall", 32'(st0), 1);
    rst = 1'b1;
    #1;
    chk("inrst_stall", 32'(st0), 0);
    tick();
    chk("midrst_ov", 32'(ov0), 0);
    chk("midrst_sc", 32'(sc0), 0);
    rst = 1'b0;
    #1;
    chk("postrst_stall", 32'(st0), 0);
    chk("postrst_rdy", 32'(rdy0), 1);
    tick();
    chk("postrst_ov", 32'(ov0), 1);
    chk("postrst_ord", 32'(ord0), 12);
    idle();
    tick();

    // Forwarding instance: load-use gives one bubble, ALU producer none
    drv(0, 1, 0, 0, 5, 0, 0, 1, 1);
    tick();
    chk("lw_ov", 32'(ov1), 1);
    chk("lw_ord", 32'(ord1), 5);
    drv(0, 1, 5, 0, 10, 1, 0, 1, 0);
    chk("lu_stall", 32'(st1), 1);
    chk("lu_rdy", 32'(rdy1), 0);
    tick();
    chk("lu_bubble_ov", 32'(ov1), 0);
    chk("lu_after_stall", 32'(st1), 0);
    chk("lu_after_rdy", 32'(rdy1), 1);
    tick();
    chk("lu_issue_ov", 32'(ov1), 1);
    chk("lu_issue_ord", 32'(ord1), 10);
    drv(0, 1, 0, 0, 11, 0, 0, 1, 0);
    tick();
    drv(0, 1, 11, 0, 12, 1, 0, 1, 0);
    chk("alu_stall", 32'(st1), 0);
    chk("alu_rdy", 32'(rdy1), 1);
    tick();
    chk("alu_ov", 32'(ov1), 1);
    chk("alu_ord", 32'(ord1), 12);
    chk("fwd_sc", 32'(sc1), 1);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_scoreboard.md
DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 16: architectural register count; index 0 reads as zero and is never tracked.
REQ-002 Parameter DATA_W, default 16: operand width.
REQ-003 Parameter WB_LAT, default 3: accepted-cycles from ID/EX capture until the writeback value is readable in decode.
REQ-004 Parameter FWD_EN, default 0: 0 = stall on any pending source; 1 = stall only on load-use.
REQ-005 clk  in  1  global clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  decoded instruction present.
REQ-008 in_ready  out  1  decode accepts the instruction this cycle.
REQ-009 in_rs, in_rt, in_rd  in  $clog2(NUM_REGS) each  source and destination indices.
REQ-010 in_use_rs, in_use_rt  in  1 each  the source is actually read.
REQ-011 in_we, in_is_load  in  1 each  writes in_rd; the write is a memory load.
REQ-012 in_rs_data, in_rt_data  in  DATA_W each  register-file read data.
REQ-013 in_ctrl  in  CTRL_W (package constant)  opaque control bundle.
REQ-014 out_valid  out  1  ID/EX slot holds an instruction.
REQ-015 out_ready  in  1  EX accepts the slot; 0 freezes the whole pipe.
REQ-016 out_rd, out_we, out_rs_data, out_rt_data, out_ctrl  out  registered copies of the accepted inputs.
REQ-017 flush  in  1  squash the instruction in decode and in the ID/EX slot.
REQ-018 stall  out  1  hazard stall active this cycle.
REQ-019 stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-020 adv = out_ready | ~out_valid; in_ready = adv & ~stall & ~flush.
REQ-021 Per register r != 0: pending counter cnt[r] (0..WB_LAT) and flag ld[r].
REQ-022 Issue occurs when in_valid & in_ready: the slot captures the inputs and out_valid = 1 on the next edge; latency is one cycle.
REQ-023 An issue with in_we & in_rd != 0 sets cnt[in_rd] = WB_LAT and ld[in_rd] = in_is_load, overriding any older value (WAW).
REQ-024 On every edge with out_ready = 1, each nonzero cnt not set by this cycle's issue decrements by 1; ld clears when cnt reaches 0.
REQ-025 FWD_EN = 0 hazard: (in_use_rs & cnt[in_rs] != 0) | (in_use_rt & cnt[in_rt] != 0).
REQ-026 FWD_EN = 1 hazard: a used source with ld set and cnt == WB_LAT, which gives exactly one bubble.
REQ-027 stall = in_valid & hazard & ~flush; index 0 never causes a hazard.
REQ-028 Bubble: if adv & ~in_ready, out_valid = 0 on the next edge and the payload is don't-care; out_we must be 0 whenever out_valid = 0.
REQ-029 If out_valid & ~out_ready, the slot and all counters hold their values.
REQ-030 flush has priority over issue and stall:
- the slot is invalidated;
- if the slot held a valid writing instruction, its cnt[out_rd] and ld[out_rd] clear unless issue in the same cycle reloads them.
REQ-031 stall_cnt increments on each cycle with stall = 1 and saturates at 16'hFFFF.

Reset
REQ-032 On rst at a clock edge:
- all cnt = 0, all ld = 0;
- out_valid = 0, out_we = 0, out_rd = 0, out data = 0, out_ctrl = 0;
- stall_cnt = 0.
REQ-033 rst overrides flush, issue and backpressure; in-flight instructions are discarded and no counter survives.
REQ-034 During and after rst, stall = 0 until the next accepted issue; in_ready depends only on REQ-020.

Structure
REQ-035 Shared package decode_pkg holds: CTRL_W, the regaddr_t typedef, the idex_payload_t struct (rd, we, data, ctrl), and the FWD_EN enumeration.
REQ-036 One sub-module, sb_entry, implements a single counter and load flag; it is instantiated NUM_REGS-1 times by generate.
REQ-037 Hazard compare logic is combinational; all state is updated in a single clocked process per entry and one for the slot.

Verification
REQ-038 Back-to-back RAW, FWD_EN=0, WB_LAT=3: ADD r2 then SUB reading r2 -> stall high 3 cycles, SUB issues on the 4th, stall_cnt = 3.
REQ-039 Load-use, FWD_EN=1: LW r5 then ADD reading r5 -> exactly 1 bubble (out_valid=0 for 1 cycle); an ALU producer instead gives 0 bubbles.
REQ-040 Backpressure: hold out_ready=0 for 4 cycles with cnt[r2]=2 -> cnt stays 2 and the slot is unchanged; it resumes counting after release.
REQ-041 Flush: flush while the slot holds a write to r7 and decode reads r7 -> out_valid=0, cnt[r7]=0, and the next r7 reader is not stalled.
REQ-042 Edge cases: a source of r0 with any pending state -> no stall; a WAW rewrite of r3 at cnt=1 -> cnt[r3]=3.
REQ-043 Reset mid-stall: assert rst with cnt[r4]=2 and stall=1 -> next cycle all cnt=0, out_valid=0, stall_cnt=0.
